// File: rtl/stepper_move_ctrl_if.sv
// Host/driver signal bundle for the stepper move sequencer.
// master: host side (drives the command, observes pulses and status).
// slave:  sequencer side (consumes the command, drives pulses and status).
//   start, dir, steps, period, abort   host -> sequencer command/control
//   forw, rev                          step pulses toward the motor driver
//   busy, done, aborted                move status
//   steps_left, pos                    remaining steps and absolute position
interface stepper_move_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8,
  parameter int POS_W = 16
);
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] steps;
  logic [PER_W-1:0] period;
  logic             abort;
  logic             forw;
  logic             rev;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;
  logic [POS_W-1:0] pos;

  modport master (
    output start, dir, steps, period, abort,
    input  forw, rev, busy, done, aborted, steps_left, pos
  );

  modport slave (
    input  start, dir, steps, period, abort,
    output forw, rev, busy, done, aborted, steps_left, pos
  );
endinterface

// File: rtl/stepper_move_ctrl.sv
// Move sequencer for the 4-phase stepper driver.
// Accepts a move (step count, direction, period) and emits one-cycle forw/rev
// pulses at the programmed rate while tracking a signed absolute position.
// Ports:
//   drv_clk  clock, all state on the rising edge
//   reset    synchronous, active-high
//   bus      stepper_move_ctrl_if.slave (command in, pulses/status out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; command latched on acceptance
// RUN     | counting period, issuing one pulse per timer expiry
// DONE    | one-cycle wind-down; done is raised on the way back to IDLE
module stepper_move_ctrl #(
  parameter int CNT_W = 8,
  parameter int PER_W = 8,
  parameter int POS_W = 16
) (
  input  logic drv_clk,
  input  logic reset,
  stepper_move_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic             dir_q;
  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] timer;
  logic [CNT_W-1:0] steps_left_q;
  logic [POS_W-1:0] pos_q;
  logic             forw_q;
  logic             rev_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic [PER_W-1:0] per_eff;

  // A zero period would never let the timer expire; run it as one cycle.
  assign per_eff = (bus.period == '0) ? PER_W'(1) : bus.period;

  always_ff @(posedge drv_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      dir_q        <= 1'b0;
      per_q        <= '0;
      timer        <= '0;
      steps_left_q <= '0;
      pos_q        <= '0;
      forw_q       <= 1'b0;
      rev_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      forw_q <= 1'b0;
      rev_q  <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            dir_q     <= bus.dir;
            per_q     <= per_eff;
            aborted_q <= 1'b0;
            if (bus.steps != '0) begin
              steps_left_q <= bus.steps;
              timer        <= per_eff - PER_W'(1);
              busy_q       <= 1'b1;
              state        <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            // Abort wins over a pulse due on the same edge.
            aborted_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= ST_DONE;
          end else if (timer != '0) begin
            timer <= timer - PER_W'(1);
          end else begin
            forw_q       <= ~dir_q;
            rev_q        <= dir_q;
            pos_q        <= dir_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
            steps_left_q <= steps_left_q - CNT_W'(1);
            timer        <= per_q - PER_W'(1);
            if (steps_left_q == CNT_W'(1)) begin
              busy_q <= 1'b0;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.forw       = forw_q;
  assign bus.rev        = rev_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.steps_left = steps_left_q;
  assign bus.pos        = pos_q;

endmodule
